// File: rtl/div_pkg.sv
// ============================================================================
// div_pkg : shared constants and state encoding for the iterative divider
// Rev 1.0
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REGW_DEF = 5;

  localparam logic [2:0] FUNCT3_DIV  = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU = 3'b101;
  localparam logic [2:0] FUNCT3_REM  = 3'b110;
  localparam logic [2:0] FUNCT3_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/div_unit_step.sv
// ============================================================================
// div_unit_step : one restoring-division iteration (shift, compare, subtract)
// Rev 1.0
// ============================================================================
`default_nettype none

module div_unit_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quot_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quot_o
);

  logic [W:0] w_shift;
  logic       w_ge;

  // The partial remainder stays below the divisor, so the difference fits in W bits.
  assign w_shift = {rem_i, quot_i[W-1]};
  assign w_ge    = (w_shift >= {1'b0, divisor_i});
  assign rem_o   = w_ge ? (w_shift[W-1:0] - divisor_i) : w_shift[W-1:0];
  assign quot_o  = {quot_i[W-2:0], w_ge};

endmodule

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// div_unit : radix-2 restoring divider for DIV/DIVU/REM/REMU, fixed latency
// Rev 1.0
// ============================================================================
`default_nettype none

module div_unit
  import div_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int REGW = REGW_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic            valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [REGW-1:0] rd_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic [REGW-1:0] rd_o,
  output logic [XLEN-1:0] result_o
);

  localparam int              CNTW  = $clog2(XLEN + 1);
  localparam logic [CNTW-1:0] ITERS = CNTW'(XLEN);

  state_e            state_q;
  logic [CNTW-1:0]   cnt_q;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   quot_q;
  logic [XLEN-1:0]   divisor_q;
  logic [REGW-1:0]   tag_q;
  logic              is_rem_q;
  logic              qneg_q;
  logic              rneg_q;
  logic              div0_q;
  logic              ready_q;
  logic              busy_q;
  logic [REGW-1:0]   rd_q;
  logic [XLEN-1:0]   result_q;

  logic              w_accept;
  logic              w_rs1_neg;
  logic              w_rs2_neg;
  logic [XLEN-1:0]   w_rs1_abs;
  logic [XLEN-1:0]   w_rs2_abs;
  logic [XLEN-1:0]   w_rem_d;
  logic [XLEN-1:0]   w_quot_d;
  logic [XLEN-1:0]   w_quot_res;
  logic [XLEN-1:0]   w_rem_res;
  logic [XLEN-1:0]   w_result_d;

  assign w_accept  = start_i && valid_i && funct3_i[2] && !flush_i;
  assign w_rs1_neg = !funct3_i[0] && rs1_i[XLEN-1];
  assign w_rs2_neg = !funct3_i[0] && rs2_i[XLEN-1];
  assign w_rs1_abs = w_rs1_neg ? (~rs1_i + 1'b1) : rs1_i;
  assign w_rs2_abs = w_rs2_neg ? (~rs2_i + 1'b1) : rs2_i;

  div_unit_step #(.W(XLEN)) u_step (
    .rem_i     (rem_q),
    .quot_i    (quot_q),
    .divisor_i (divisor_q),
    .rem_o     (w_rem_d),
    .quot_o    (w_quot_d)
  );

  // A zero divisor leaves the remainder as |rs1|, which the sign fix-up turns back into rs1.
  assign w_quot_res = div0_q ? '1 : (qneg_q ? (~quot_q + 1'b1) : quot_q);
  assign w_rem_res  = rneg_q ? (~rem_q + 1'b1) : rem_q;
  assign w_result_d = is_rem_q ? w_rem_res : w_quot_res;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      tag_q     <= '0;
      is_rem_q  <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      div0_q    <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      rd_q      <= '0;
      result_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_accept) begin
            state_q   <= CALC;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            rem_q     <= '0;
            quot_q    <= w_rs1_abs;
            divisor_q <= w_rs2_abs;
            tag_q     <= rd_i;
            is_rem_q  <= funct3_i[1];
            qneg_q    <= w_rs1_neg ^ w_rs2_neg;
            rneg_q    <= w_rs1_neg;
            div0_q    <= (rs2_i == '0);
          end
        end
        CALC: begin
          if (flush_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == ITERS) begin
            state_q  <= DONE;
            ready_q  <= 1'b1;
            result_q <= w_result_d;
            rd_q     <= tag_q;
          end else begin
            rem_q  <= w_rem_d;
            quot_q <= w_quot_d;
            cnt_q  <= cnt_q + CNTW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign busy_o   = busy_q;
  assign rd_o     = rd_q;
  assign result_o = result_q;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// tb_div_unit : directed and randomized checks of div_unit against an arithmetic model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_div_unit;

  logic        clk;
  logic        reset_n;
  logic        start_i;
  logic        flush_i;
  logic        valid_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [4:0]  rd_i;
  logic        ready_o;
  logic        busy_o;
  logic [4:0]  rd_o;
  logic [31:0] result_o;

  int n_total;
  int n_pass;

  div_unit dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_i  (start_i),
    .flush_i  (flush_i),
    .valid_i  (valid_i),
    .funct3_i (funct3_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .rd_i     (rd_i),
    .ready_o  (ready_o),
    .busy_o   (busy_o),
    .rd_o     (rd_o),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'b100:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : $unsigned(sa / sb));
      3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110:  return (b == 0) ? a : (ovf ? 32'h0 : $unsigned(sa % sb));
      3'b111:  return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  task automatic idle_inputs();
    start_i  = 1'b0;
    valid_i  = 1'b0;
    flush_i  = 1'b0;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    start_i  = 1'b1;
    valid_i  = 1'b1;
    funct3_i = f3;
    rs1_i    = a;
    rs2_i    = b;
    rd_i     = rd;
    @(posedge clk);
    #1;
    idle_inputs();
    funct3_i = 3'($urandom);
    rs1_i    = $urandom;
    rs2_i    = $urandom;
    rd_i     = 5'($urandom);
  endtask

  // poke > 0 pulses a competing start at that many cycles after acceptance
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int poke);
    logic [31:0] exp;
    int          lat;
    exp = ref_model(f3, a, b);
    issue(f3, a, b, rd);
    n_total++;
    if (busy_o !== 1'b1) $display("FAIL %s busy_after_accept got=%b want=1", name, busy_o);
    else n_pass++;
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (ready_o === 1'b1) lat = k;
      if (k == poke) begin
        start_i  = 1'b1;
        valid_i  = 1'b1;
        funct3_i = 3'b101;
        rs1_i    = 32'd77;
        rs2_i    = 32'd7;
        rd_i     = 5'd3;
      end else begin
        start_i = 1'b0;
        valid_i = 1'b0;
      end
    end
    idle_inputs();
    n_total++;
    if (lat != 33) $display("FAIL %s latency got=%0d want=33", name, lat);
    else n_pass++;
    n_total++;
    if (result_o !== exp) $display("FAIL %s result got=%h want=%h", name, result_o, exp);
    else n_pass++;
    n_total++;
    if (rd_o !== rd) $display("FAIL %s rd got=%0d want=%0d", name, rd_o, rd);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (ready_o !== 1'b0 || busy_o !== 1'b0 || result_o !== exp)
      $display("FAIL %s after_done ready=%b busy=%b result=%h want 0/0/%h",
               name, ready_o, busy_o, result_o, exp);
    else n_pass++;
  endtask

  task automatic test_reset();
    idle_inputs();
    funct3_i = 3'b000;
    rs1_i    = '0;
    rs2_i    = '0;
    rd_i     = '0;
    reset_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({ready_o, busy_o, rd_o, result_o} !== '0)
      $display("FAIL reset outputs ready=%b busy=%b rd=%0d result=%h want all 0",
               ready_o, busy_o, rd_o, result_o);
    else n_pass++;
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op("div_neg40_8",   3'b100, 32'hFFFF_FFD8, 32'd8,          5'd10, 0);
    run_op("divu_40_8",     3'b101, 32'd40,        32'd8,          5'd11, 0);
    run_op("rem_neg40_6",   3'b110, 32'hFFFF_FFD8, 32'd6,          5'd12, 0);
    run_op("remu_40_6",     3'b111, 32'd40,        32'd6,          5'd13, 0);
    run_op("remu_199_197",  3'b111, 32'd199,       32'd197,        5'd14, 0);
    run_op("remu_big",      3'b111, 32'hFFFF_FFFF, 32'hFE98_F000,  5'd15, 0);
    run_op("divu_big",      3'b101, 32'hFFFF_FFFF, 32'hFE98_F000,  5'd16, 0);
  endtask

  task automatic test_special();
    run_op("div_by_zero",   3'b100, 32'd123,       32'd0,          5'd17, 0);
    run_op("rem_by_zero",   3'b110, 32'd123,       32'd0,          5'd18, 0);
    run_op("divu_by_zero",  3'b101, 32'hDEAD_BEEF, 32'd0,          5'd19, 0);
    run_op("rem_neg_by_0",  3'b110, 32'hFFFF_FF85, 32'd0,          5'd20, 0);
    run_op("div_0_m1",      3'b100, 32'd0,         32'hFFFF_FFFF,  5'd21, 0);
    run_op("div_overflow",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF,  5'd22, 0);
    run_op("rem_overflow",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF,  5'd23, 0);
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 24; i++) begin
      f3 = 3'(4 + $urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'($urandom_range(1, 20));
        1:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 9));
        2:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      run_op("random", f3, a, b, 5'($urandom), 0);
    end
  endtask

  task automatic test_busy_ignore();
    run_op("start_while_busy", 3'b110, 32'hFFFF_F000, 32'd37, 5'd9, 5);
  endtask

  task automatic test_flush();
    int seen;
    issue(3'b100, 32'd1000, 32'd7, 5'd4);
    repeat (10) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    n_total++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0)
      $display("FAIL flush_outputs busy=%b ready=%b want 0/0", busy_o, ready_o);
    else n_pass++;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (ready_o === 1'b1 || busy_o === 1'b1) seen++;
    end
    n_total++;
    if (seen != 0) $display("FAIL flush_no_result active_cycles got=%0d want=0", seen);
    else n_pass++;
    run_op("after_flush", 3'b100, 32'hFFFF_FC18, 32'd7, 5'd5, 0);
  endtask

  task automatic test_reject();
    int seen;
    @(negedge clk);
    start_i  = 1'b1;
    valid_i  = 1'b1;
    funct3_i = 3'b000;
    rs1_i    = 32'd50;
    rs2_i    = 32'd5;
    rd_i     = 5'd7;
    @(posedge clk);
    #1;
    funct3_i = 3'b100;
    flush_i  = 1'b1;
    seen = (busy_o === 1'b1) ? 1 : 0;
    @(posedge clk);
    #1;
    idle_inputs();
    funct3_i = 3'b101;
    start_i  = 1'b1;
    valid_i  = 1'b0;
    if (busy_o === 1'b1) seen++;
    @(posedge clk);
    #1;
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      if (busy_o === 1'b1 || ready_o === 1'b1) seen++;
      @(posedge clk);
      #1;
    end
    n_total++;
    if (seen != 0) $display("FAIL reject_requests busy_cycles got=%0d want=0", seen);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    issue(3'b101, 32'd999, 32'd10, 5'd8);
    repeat (6) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    n_total++;
    if ({ready_o, busy_o, rd_o, result_o} !== '0)
      $display("FAIL reset_mid outputs ready=%b busy=%b rd=%0d result=%h want all 0",
               ready_o, busy_o, rd_o, result_o);
    else n_pass++;
    reset_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    n_total++;
    if (ready_o !== 1'b0 || busy_o !== 1'b0 || result_o !== 32'h0)
      $display("FAIL reset_mid_lost ready=%b busy=%b result=%h want 0/0/0",
               ready_o, busy_o, result_o);
    else n_pass++;
    run_op("after_reset", 3'b111, 32'd1234567, 32'd1000, 5'd31, 0);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    test_reset();
    test_directed();
    test_special();
    test_busy_ignore();
    test_flush();
    test_reject();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
